// File: rtl/sdc_write_buffer.sv
// sdc_write_buffer: byte-wide show-ahead FIFO feeding the SD-card writer.
// Host bytes enter through valid/ready. The buffer counts them into 512-byte
// blocks, reports how many complete blocks have been loaded, and on flush pads
// a partial block out to its boundary with 0xFF.
module sdc_write_buffer #(
    parameter int AW          = 4,
    parameter int BLOCK_BYTES = 512
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] wr_data,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic       flush,
    output logic [7:0] dataFromRam,
    output logic       empty,
    input  logic       bytes,
    output logic [7:0] sizeRead,
    output logic       start,
    output logic       busy
);

    localparam int             DEPTH    = 1 << AW;
    localparam int             BW       = $clog2(BLOCK_BYTES);
    localparam logic [AW:0]    FULL_OCC = (AW + 1)'(DEPTH);
    localparam logic [BW-1:0]  BLK_LAST = BW'(BLOCK_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        PAD  = 2'd2
    } state_t;

    state_t         state_reg, state_next;
    logic [AW-1:0]  wrPtr_reg, rdPtr_reg;
    logic [AW:0]    occ_reg;
    logic [BW-1:0]  blkCnt_reg;
    logic [7:0]     sizeRead_reg;
    logic           start_reg, startSeen_reg;
    logic [7:0]     mem [DEPTH];

    logic           full;
    logic           hostPush, padPush, pushEn, popEn, blkWrap;
    logic [7:0]     pushData;

    assign full  = (occ_reg == FULL_OCC);
    assign empty = (occ_reg == '0);

    // Ready is held low while reset is asserted so the host never sees a
    // handshake against a buffer that is being cleared.
    assign wr_ready = reset & ~full & (state_reg != PAD);

    assign hostPush = wr_valid & wr_ready;
    assign padPush  = (state_reg == PAD) & ~full;
    assign pushEn   = hostPush | padPush;
    assign popEn    = bytes & ~empty;
    assign blkWrap  = pushEn & (blkCnt_reg == BLK_LAST);
    assign pushData = padPush ? 8'hFF : wr_data;

    // Stale storage contents are masked so an empty buffer always reads 0x00.
    assign dataFromRam = empty ? 8'h00 : mem[rdPtr_reg];
    assign sizeRead    = sizeRead_reg;
    assign start       = start_reg;
    assign busy        = (state_reg == PAD);

    // Storage write port; contents need no reset because occupancy gates reads.
    always_ff @(posedge clk) begin
        if (pushEn) begin
            mem[wrPtr_reg] <= pushData;
        end
    end

    // Pointers, occupancy, block accounting and the one-shot start pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr_reg     <= '0;
            rdPtr_reg     <= '0;
            occ_reg       <= '0;
            blkCnt_reg    <= '0;
            sizeRead_reg  <= '0;
            start_reg     <= 1'b0;
            startSeen_reg <= 1'b0;
        end else begin
            if (pushEn) begin
                wrPtr_reg  <= wrPtr_reg + 1'b1;
                blkCnt_reg <= blkCnt_reg + 1'b1;
            end
            if (popEn) begin
                rdPtr_reg <= rdPtr_reg + 1'b1;
            end
            case ({pushEn, popEn})
                2'b10:   occ_reg <= occ_reg + 1'b1;
                2'b01:   occ_reg <= occ_reg - 1'b1;
                default: occ_reg <= occ_reg;
            endcase
            if (blkWrap && (sizeRead_reg != 8'hFF)) begin
                sizeRead_reg <= sizeRead_reg + 1'b1;
            end
            // Pulse once, the cycle after the first block becomes visible.
            start_reg     <= (sizeRead_reg == 8'd1) & ~startSeen_reg;
            startSeen_reg <= startSeen_reg | (sizeRead_reg == 8'd1);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: block completion always wins over a same-cycle flush.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (hostPush) begin
                    state_next = blkWrap ? IDLE : FILL;
                end
            end
            FILL: begin
                if (blkWrap) begin
                    state_next = IDLE;
                end else if (flush) begin
                    state_next = PAD;
                end
            end
            PAD: begin
                if (blkWrap) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: doc/sdc_write_buffer.md
Name: sdc_write_buffer

Overview:
- Byte-wide show-ahead FIFO between the host-side byte source and the SD-card writer.
- Upstream: accepts bytes from the host through a valid/ready handshake and tracks 512-byte block boundaries.
- Downstream: presents bytes to the writer as dataFromRam/empty and pops one byte per `bytes` strobe.
- Publishes sizeRead (number of complete blocks loaded) and a start pulse. On flush, pads a partial final block with 0xFF.

Parameters:
- AW, 4, FIFO address width; depth = 2^AW bytes (default 16).
- BLOCK_BYTES, 512, bytes per SD block; power of two, at least 2^AW.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- wr_data  input  8  host byte
- wr_valid  input  1  host byte valid
- wr_ready  output  1  buffer can accept a byte this cycle
- flush  input  1  one-cycle request to close the current partial block
- dataFromRam  output  8  head-of-FIFO byte; valid while empty=0
- empty  output  1  FIFO holds no bytes
- bytes  input  1  writer pop strobe; one byte per cycle while high
- sizeRead  output  8  complete blocks loaded since reset, saturating at 255
- start  output  1  one-cycle pulse when sizeRead goes 0->1
- busy  output  1  high while in PAD state

Behaviour:
- Reset (reset=0, async): pointers, occupancy, block byte counter and sizeRead cleared; state IDLE.
  - Outputs during and after reset: wr_ready=0 while reset=0 and 1 after release; dataFromRam=8'h00; empty=1; start=0; busy=0.
- Storage and occupancy:
  - Storage: 2^AW x 8 register array; wr_ptr/rd_ptr are AW bits and wrap naturally.
  - occ counter is AW+1 bits, 0..2^AW.
  - full = (occ == 2^AW); empty = (occ == 0).
- Push: occurs when push_en=1, where push_en = wr_valid & wr_ready in FILL/IDLE, or the internal pad push in PAD.
  - A push writes mem[wr_ptr], increments wr_ptr and increments blk_cnt (log2(BLOCK_BYTES) bits).
- Pop: occurs when bytes=1 and empty=0; increments rd_ptr. A pop with empty=1 is ignored with no error.
- Show-ahead output: dataFromRam = mem[rd_ptr], combinational from registered state. A byte written at edge N is visible with empty=0 after edge N, so write-to-read latency is 1 cycle.
- Simultaneous push and pop: both occur and occ is unchanged.
  - If empty, only the push happens, since the pop is ignored.
  - If full, wr_ready=0, so only the pop happens.
- wr_ready = ~full & (state != PAD).
- Block accounting:
  - When a push makes blk_cnt wrap from BLOCK_BYTES-1 to 0, sizeRead increments (holds at 255).
  - start is registered and pulses for exactly one cycle, on the cycle after sizeRead changes 0->1. It never pulses again until reset.
- State machine:
  - IDLE: blk_cnt==0. A host push moves to FILL. flush is ignored (no partial block), so no padding occurs.
  - FILL: blk_cnt!=0, host pushes allowed.
    - Block completion returns to IDLE.
    - flush=1 moves to PAD on the next edge. If flush and a push arrive in the same cycle, the push is accepted first, then PAD pads the remainder.
    - If that push completes the block, the state goes to IDLE instead and the flush is dropped.
  - PAD: busy=1; host blocked. Each cycle with ~full, pushes 8'hFF.
    - The push that wraps blk_cnt to 0 increments sizeRead and returns to IDLE.
    - Stalls (no push) while full; pops continue normally.
  - flush in PAD is ignored.
- Reset mid-operation (including PAD): all contents discarded, sizeRead=0, state IDLE.

Test Plan:
- Reset, then 5 host bytes 0x10..0x14 with bytes=0 -> empty falls 1 cycle after first push; dataFromRam=0x10; sizeRead=0; occ=5.
- Fill to 16 bytes with bytes=0 -> wr_ready=0 at occ=16; a 17th byte held on wr_valid is not accepted. Assert bytes for 1 cycle -> wr_ready=1 next cycle; the held byte is accepted; dataFromRam advances to the second byte.
- Stream 512 bytes (0x00..0xFF twice) while popping every cycle -> no data loss; popped order is identical; sizeRead 0->1; start high for exactly 1 cycle; state back to IDLE.
- Push 3 bytes, pulse flush -> busy=1; 509 bytes of 0xFF follow the 3 host bytes at the pop side; sizeRead increments once; busy drops; wr_ready blocked throughout PAD.
- Pulse flush in IDLE -> no push, busy stays 0, sizeRead unchanged. Pop with empty=1 -> no pointer change.
- Assert reset=0 mid-PAD with occ=9 -> immediately empty=1, sizeRead=0, busy=0, start=0. After release, a fresh byte 0xAB appears at dataFromRam.
